// File: rtl/bp_be_late_wb_queue_pkg.sv
// Shared types and defaults for the late writeback queue.
// The writeback packet layout is common to the integer and float lanes.
package bp_be_late_wb_queue_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg        = 2'd0,
        e_bp_unicore_half_cfg   = 2'd1
    } bp_params_e;

    localparam int bp_be_late_wb_starve_limit_gp = 8;
    localparam int rv64_reg_addr_width_gp        = 5;
    localparam int dword_width_gp                = 64;
    localparam int fflags_width_gp               = 5;

    typedef struct packed {
        logic                              ird_w_v;
        logic                              frd_w_v;
        logic [rv64_reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]         rd_data;
        logic                              fflags_w_v;
        logic [fflags_width_gp-1:0]        fflags;
    } bp_be_wb_pkt_s;

    localparam int bp_be_wb_pkt_width_gp = $bits(bp_be_wb_pkt_s);

    // Every supported configuration shares the same packet layout today.
    function automatic int wb_pkt_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return bp_be_wb_pkt_width_gp;
            default:          return bp_be_wb_pkt_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_late_wb_queue_lane.sv
// One late writeback lane: small FIFO, starvation counter and optional bypass.
// Define BP_LATE_WB_BYPASS_EN to let an empty lane forward its input in the same cycle.
module bp_be_late_wb_queue_lane
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter int width_p        = bp_be_wb_pkt_width_gp,
    parameter int depth_p        = 2,
    parameter int starve_limit_p = bp_be_late_wb_starve_limit_gp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] pkt_i,
    input  logic               v_i,
    output logic               yumi_o,
    input  logic               port_free_i,
    output logic [width_p-1:0] pkt_o,
    output logic               pkt_v_o,
    output logic               stall_req_o,
    output logic               empty_o
);

    localparam int ptr_w_lp    = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp    = $clog2(depth_p + 1);
    localparam int starve_w_lp = $clog2(starve_limit_p + 1);

    localparam logic [ptr_w_lp-1:0]    last_ptr_lp   = ptr_w_lp'(depth_p - 1);
    localparam logic [cnt_w_lp-1:0]    full_cnt_lp   = cnt_w_lp'(depth_p);
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

    logic [width_p-1:0]     mem_q [depth_p];
    logic [width_p-1:0]     mem_d [depth_p];
    logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]    count_q, count_d;
    logic [starve_w_lp-1:0] starve_q, starve_d;

    logic empty, full, deq, enq, byp;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == full_cnt_lp);
        deq   = ~empty & port_free_i;
`ifdef BP_LATE_WB_BYPASS_EN
        byp   = empty & v_i & port_free_i;
`else
        byp   = 1'b0;
`endif
        // Full is acceptable when the head leaves this same cycle.
        yumi_o  = reset_n_i & v_i & (~full | deq);
        enq     = yumi_o & ~byp;
        pkt_v_o = deq | byp;
        pkt_o   = byp ? pkt_i : mem_q[rd_ptr_q];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = pkt_i;
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Counts cycles the head has been waiting on a busy port.
        starve_d = starve_q;
        if (deq || empty) begin
            starve_d = '0;
        end else if (!port_free_i && (starve_q != starve_max_lp)) begin
            starve_d = starve_q + 1'b1;
        end

        stall_req_o = (starve_q == starve_max_lp);
        empty_o     = empty;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// Late writeback queue: independent integer and float lanes feeding the regfile late ports.
// Define BP_LATE_WB_BYPASS_EN for same-cycle forwarding through an empty lane.
module bp_be_late_wb_queue
    import bp_be_late_wb_queue_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_default_cfg,
    parameter int         depth_p        = 2,
    parameter int         starve_limit_p = bp_be_late_wb_starve_limit_gp,
    localparam int        wb_pkt_width_lp = wb_pkt_width(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [wb_pkt_width_lp-1:0] late_iwb_pkt_i,
    input  logic                       late_iwb_pkt_v_i,
    output logic                       late_iwb_pkt_yumi_o,

    input  logic [wb_pkt_width_lp-1:0] late_fwb_pkt_i,
    input  logic                       late_fwb_pkt_v_i,
    output logic                       late_fwb_pkt_yumi_o,

    input  logic                       iwb_port_free_i,
    input  logic                       fwb_port_free_i,

    output logic [wb_pkt_width_lp-1:0] iwb_pkt_o,
    output logic                       iwb_pkt_v_o,
    output logic [wb_pkt_width_lp-1:0] fwb_pkt_o,
    output logic                       fwb_pkt_v_o,

    output logic                       istall_req_o,
    output logic                       fstall_req_o,
    output logic                       empty_o
);

    logic i_empty, f_empty;

    bp_be_late_wb_queue_lane #(
        .width_p        (wb_pkt_width_lp),
        .depth_p        (depth_p),
        .starve_limit_p (starve_limit_p)
    ) u_int_lane (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .pkt_i       (late_iwb_pkt_i),
        .v_i         (late_iwb_pkt_v_i),
        .yumi_o      (late_iwb_pkt_yumi_o),
        .port_free_i (iwb_port_free_i),
        .pkt_o       (iwb_pkt_o),
        .pkt_v_o     (iwb_pkt_v_o),
        .stall_req_o (istall_req_o),
        .empty_o     (i_empty)
    );

    bp_be_late_wb_queue_lane #(
        .width_p        (wb_pkt_width_lp),
        .depth_p        (depth_p),
        .starve_limit_p (starve_limit_p)
    ) u_fp_lane (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .pkt_i       (late_fwb_pkt_i),
        .v_i         (late_fwb_pkt_v_i),
        .yumi_o      (late_fwb_pkt_yumi_o),
        .port_free_i (fwb_port_free_i),
        .pkt_o       (fwb_pkt_o),
        .pkt_v_o     (fwb_pkt_v_o),
        .stall_req_o (fstall_req_o),
        .empty_o     (f_empty)
    );

    // A packet waiting at the input still counts as work outstanding.
    assign empty_o = i_empty & f_empty & ~late_iwb_pkt_v_i & ~late_fwb_pkt_v_i;

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Randomized scoreboard bench for bp_be_late_wb_queue against a queue-based reference model.
module tb_bp_be_late_wb_queue;
    import bp_be_late_wb_queue_pkg::*;

    localparam int W     = $bits(bp_be_wb_pkt_s);
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
`ifdef BP_LATE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] ipkt, fpkt, iout, fout;
    logic         iv, fv, iyumi, fyumi, ifree, ffree;
    logic         iout_v, fout_v, istall, fstall, empty;

    always #5 clk = ~clk;

    bp_be_late_wb_queue #(
        .bp_params_p    (e_bp_default_cfg),
        .depth_p        (DEPTH),
        .starve_limit_p (LIMIT)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .late_iwb_pkt_i      (ipkt),
        .late_iwb_pkt_v_i    (iv),
        .late_iwb_pkt_yumi_o (iyumi),
        .late_fwb_pkt_i      (fpkt),
        .late_fwb_pkt_v_i    (fv),
        .late_fwb_pkt_yumi_o (fyumi),
        .iwb_port_free_i     (ifree),
        .fwb_port_free_i     (ffree),
        .iwb_pkt_o           (iout),
        .iwb_pkt_v_o         (iout_v),
        .fwb_pkt_o           (fout),
        .fwb_pkt_v_o         (fout_v),
        .istall_req_o        (istall),
        .fstall_req_o        (fstall),
        .empty_o             (empty)
    );

    // Reference model: in-flight packets per lane, and blocked-cycle counts.
    logic [W-1:0] exp_iq[$];
    logic [W-1:0] exp_fq[$];
    int           ctr [2];
    bit           exp_yumi [2];
    bit           exp_v [2];
    bit           exp_stall [2];
    bit           exp_empty;
    bit           check_en = 1'b0;
    bit           i_hold = 1'b0;
    bit           f_hold = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [4:0] ra);
        bp_be_wb_pkt_s p;
        p.ird_w_v    = 1'($urandom_range(0, 1));
        p.frd_w_v    = 1'($urandom_range(0, 1));
        p.rd_addr    = ra;
        p.rd_data    = {$urandom, $urandom};
        p.fflags_w_v = 1'($urandom_range(0, 1));
        p.fflags     = 5'($urandom_range(0, 31));
        return p;
    endfunction

    // One cycle of stimulus; a refused packet is held unchanged when still valid.
    task automatic drive(input bit v_i, input bit fr_i, input bit v_f, input bit fr_f,
                         input logic [4:0] ra_i, input logic [4:0] ra_f);
        int isz, fsz;
        @(posedge clk);
        #1;
        if (!(v_i && i_hold)) ipkt = mk(ra_i);
        if (!(v_f && f_hold)) fpkt = mk(ra_f);
        iv = v_i; ifree = fr_i; fv = v_f; ffree = fr_f;
        isz = exp_iq.size();
        fsz = exp_fq.size();
        exp_v[0]     = (isz != 0 && fr_i) || (BYP && isz == 0 && v_i && fr_i);
        exp_v[1]     = (fsz != 0 && fr_f) || (BYP && fsz == 0 && v_f && fr_f);
        exp_yumi[0]  = v_i && (isz < DEPTH || (isz != 0 && fr_i));
        exp_yumi[1]  = v_f && (fsz < DEPTH || (fsz != 0 && fr_f));
        exp_stall[0] = (ctr[0] == LIMIT);
        exp_stall[1] = (ctr[1] == LIMIT);
        exp_empty    = (isz == 0) && (fsz == 0) && !v_i && !v_f;
        check_en = 1'b1;
    endtask

    // Monitor: compares handshakes and pops written packets in FIFO order.
    always @(negedge clk) begin
        int isz, fsz;
        logic [W-1:0] head;
        if (check_en) begin
            check_en = 1'b0;
            isz = exp_iq.size();
            fsz = exp_fq.size();
            chk("iyumi",  W'(iyumi),  W'(exp_yumi[0]));
            chk("fyumi",  W'(fyumi),  W'(exp_yumi[1]));
            chk("iwb_v",  W'(iout_v), W'(exp_v[0]));
            chk("fwb_v",  W'(fout_v), W'(exp_v[1]));
            chk("istall", W'(istall), W'(exp_stall[0]));
            chk("fstall", W'(fstall), W'(exp_stall[1]));
            chk("empty",  W'(empty),  W'(exp_empty));
            if (exp_yumi[0]) exp_iq.push_back(ipkt);
            if (exp_yumi[1]) exp_fq.push_back(fpkt);
            i_hold = iv && !exp_yumi[0];
            f_hold = fv && !exp_yumi[1];
            if (exp_v[0]) begin
                head = exp_iq.pop_front();
                chk("iwb_pkt", iout, head);
            end
            if (exp_v[1]) begin
                head = exp_fq.pop_front();
                chk("fwb_pkt", fout, head);
            end
            if (exp_v[0] || isz == 0) ctr[0] = 0;
            else if (!ifree && ctr[0] < LIMIT) ctr[0]++;
            if (exp_v[1] || fsz == 0) ctr[1] = 0;
            else if (!ffree && ctr[1] < LIMIT) ctr[1]++;
        end
    end

    task automatic model_clear();
        exp_iq.delete();
        exp_fq.delete();
        ctr[0] = 0;
        ctr[1] = 0;
        i_hold = 1'b0;
        f_hold = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_iq.size() != 0 || exp_fq.size() != 0) && guard < 20) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
            guard++;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("drain_budget", W'(guard < 20), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int free_pct_i, free_pct_f;
        rst_n = 1'b0;
        iv = 1'b1; fv = 1'b1; ifree = 1'b1; ffree = 1'b1;
        ipkt = mk(5'd0); fpkt = mk(5'd0);
        model_clear();
        #1;
        chk("rst_iyumi", W'(iyumi), W'(0));
        chk("rst_fyumi", W'(fyumi), W'(0));
        iv = 1'b0; fv = 1'b0;
        #1;
        chk("rst_iwb_v",  W'(iout_v), W'(0));
        chk("rst_fwb_v",  W'(fout_v), W'(0));
        chk("rst_istall", W'(istall), W'(0));
        chk("rst_fstall", W'(fstall), W'(0));
        chk("rst_empty",  W'(empty),  W'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single integer packet, rd_addr 5.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);

        // Float port blocked: two accepted, third refused, then full enqueue+dequeue.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd3);
        drain();

        // Starvation: one queued int packet, port blocked past the limit.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0);
        repeat (LIMIT + 2) drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("starve_ctr_model", W'(ctr[0]), W'(LIMIT));
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);

        // Simultaneous int and float traffic.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd8);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 5'd11);
        drain();

        // Randomized traffic with phases of port pressure.
        for (int ph = 0; ph < 10; ph++) begin
            free_pct_i = (ph % 4 == 0) ? 0 : 25 * ($urandom_range(1, 4));
            free_pct_f = (ph % 3 == 1) ? 0 : 25 * ($urandom_range(1, 4));
            for (int c = 0; c < 40; c++) begin
                drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < free_pct_i,
                      $urandom_range(0, 99) < 60, $urandom_range(0, 99) < free_pct_f,
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
        end
        drain();

        // Reset with two entries queued in each lane.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 5'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        chk("pre_rst_fill", W'(exp_iq.size() + exp_fq.size()), W'(4));
        check_en = 1'b0;
        ifree = 1'b1; ffree = 1'b1;
        iv = 1'b1; fv = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_iyumi", W'(iyumi),  W'(0));
        chk("mid_rst_fyumi", W'(fyumi),  W'(0));
        chk("mid_rst_iwb_v", W'(iout_v), W'(0));
        chk("mid_rst_fwb_v", W'(fout_v), W'(0));
        iv = 1'b0; fv = 1'b0;
        #1;
        chk("mid_rst_empty", W'(empty), W'(1));
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
